// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect input and IF/ID head output.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        wir;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic        valid;

    modport master (
        output imem_req, imem_addr, pc4, ins, valid,
        input  imem_ack, imem_rdata, redirect, redirect_pc, wir
    );

    modport slave (
        input  imem_req, imem_addr, pc4, ins, valid,
        output imem_ack, imem_rdata, redirect, redirect_pc, wir
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC owner, imem req/ack master, prefetch queue feeding IF/ID.
// Optional perf counters (stall_cnt, flush_cnt) when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_unit_if.master   bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t             state, state_nxt;
    entry_t             mem [DEPTH];
    entry_t             push_entry, head_nxt;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0]   count, count_pop, count_nxt;
    logic [31:0]        pc, pc_nxt, addr_nxt, redir_pc;
    logic               push, pop, xfer, space, req_nxt, valid_nxt;

    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, queue bookkeeping and fetch address
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        addr_nxt   = bus.imem_addr;
        xfer       = bus.imem_req && bus.imem_ack;
        pop        = bus.valid && bus.wir && !bus.redirect;
        push       = (state == S_WAIT) && xfer && !bus.redirect;
        push_entry = '{pc4: pc + 32'd4, ins: bus.imem_rdata};
        count_pop  = count - CNT_W'(pop);
        count_nxt  = count_pop + CNT_W'(push);
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        wr_ptr_nxt = wr_ptr + PTR_W'(push);
        space      = count_nxt < CNT_W'(DEPTH);
        if (push) pc_nxt = pc + 32'd4;

        case (state)
            S_IDLE: begin
                if (bus.redirect) begin
                    pc_nxt = redir_pc;
                end else if (space) begin
                    state_nxt = S_WAIT;
                    addr_nxt  = pc;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    pc_nxt    = redir_pc;
                    state_nxt = xfer ? S_IDLE : S_DROP;
                end else if (xfer) begin
                    // Back-to-back issue in the ack cycle when the queue still has room
                    if (space) addr_nxt = pc + 32'd4;
                    else       state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (bus.redirect) pc_nxt = redir_pc;
                if (xfer) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (bus.redirect) begin
            count_nxt  = '0;
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
        end

        req_nxt   = (state_nxt != S_IDLE);
        valid_nxt = (count_nxt != '0);
        if (count_nxt == '0)      head_nxt = '0;
        else if (count_pop == '0) head_nxt = push_entry;
        else                      head_nxt = mem[rd_ptr_nxt];
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            bus.imem_addr <= RESET_PC;
            bus.imem_req  <= 1'b0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            bus.valid     <= 1'b0;
            bus.pc4       <= '0;
            bus.ins       <= '0;
        end else begin
            pc            <= pc_nxt;
            bus.imem_addr <= addr_nxt;
            bus.imem_req  <= req_nxt;
            count         <= count_nxt;
            rd_ptr        <= rd_ptr_nxt;
            wr_ptr        <= wr_ptr_nxt;
            bus.valid     <= valid_nxt;
            bus.pc4       <= head_nxt.pc4;
            bus.ins       <= head_nxt.ins;
        end
    end

    // Queue storage needs no reset; count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!bus.valid && !bus.redirect) stall_cnt <= stall_cnt + 32'd1;
            if (bus.redirect && ((count != '0) || (state != S_IDLE)) && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
